// File: rtl/diod_pkg.sv
// Shared encodings and timing helpers for the diode window sequencer.
package diod_pkg;

    typedef enum logic [1:0] {
        MODE_ENABLE    = 2'b00,
        MODE_CALIBRATE = 2'b01,
        MODE_TEST      = 2'b10,
        MODE_RSVD      = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_SEND     = 3'd1,
        PH_INCREASE = 3'd2,
        PH_PAUSE    = 3'd3,
        PH_LISTEN   = 3'd4,
        PH_DONE     = 3'd5
    } phase_e;

    localparam int TEST_WINDOWS = 1;

    function automatic int us_to_cycles(input int us, input int clk_freq_mhz);
        return us * clk_freq_mhz;
    endfunction

endpackage

// File: rtl/window_sequencer_if.sv
// Control/status bundle between a run requester and the window sequencer.
interface window_sequencer_if #(
    parameter int WIN_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       phase;
    logic [WIN_W-1:0] window_idx;
    logic             phase_start;
    logic             lfd_off;
    logic             lfd_on;
    logic             pause_action;

    modport master (
        output start, mode, abort,
        input  busy, done, err, phase, window_idx, phase_start,
               lfd_off, lfd_on, pause_action
    );

    modport slave (
        input  start, mode, abort,
        output busy, done, err, phase, window_idx, phase_start,
               lfd_off, lfd_on, pause_action
    );
endinterface

// File: rtl/window_sequencer_timer.sv
// Loadable down-counter that holds at zero; tc_o flags the last cycle of a phase.
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/window_sequencer.sv
// Runs N measurement windows (SEND, INCREASE, PAUSE, LISTEN) for the latched
// mode and drives phase status plus the LFD/calibration strobes; all outputs registered.
module window_sequencer
    import diod_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 50,
    parameter int SEND_US        = 30,
    parameter int INCREASE_US    = 350,
    parameter int PAUSE_US       = 5,
    parameter int LISTEN_US      = 115,
    parameter int CNT_W          = 16,
    parameter int WIN_W          = 8,
    parameter int ENABLE_WINDOWS = 3,
    parameter int CALIB_WINDOWS  = 20
) (
    input  logic               clk,
    input  logic               rst,
    window_sequencer_if.slave  bus
);
    localparam int     C_SEND     = us_to_cycles(SEND_US, CLK_FREQ_MHZ);
    localparam int     C_INCREASE = us_to_cycles(INCREASE_US, CLK_FREQ_MHZ);
    localparam int     C_PAUSE    = us_to_cycles(PAUSE_US, CLK_FREQ_MHZ);
    localparam int     C_LISTEN   = us_to_cycles(LISTEN_US, CLK_FREQ_MHZ);
    localparam longint CNT_MAX    = (64'd1 << CNT_W) - 1;
    localparam longint WIN_MAX    = (64'd1 << WIN_W) - 1;

    if (C_SEND < 1 || C_SEND > CNT_MAX || C_INCREASE < 1 || C_INCREASE > CNT_MAX ||
        C_PAUSE < 1 || C_PAUSE > CNT_MAX || C_LISTEN < 1 || C_LISTEN > CNT_MAX) begin : g_bad_phase
        $error("window_sequencer: phase cycle count outside 1..2^CNT_W-1");
    end

    if (ENABLE_WINDOWS < 1 || ENABLE_WINDOWS > WIN_MAX ||
        CALIB_WINDOWS < 1 || CALIB_WINDOWS > WIN_MAX) begin : g_bad_win
        $error("window_sequencer: window count outside 1..2^WIN_W-1");
    end

    function automatic logic [WIN_W-1:0] windows_for(input mode_e m);
        case (m)
            MODE_CALIBRATE: return WIN_W'(CALIB_WINDOWS);
            MODE_TEST:      return WIN_W'(TEST_WINDOWS);
            default:        return WIN_W'(ENABLE_WINDOWS);
        endcase
    endfunction

    phase_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] count_q, count_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_tc;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic phase_start_q, phase_start_d;
    logic lfd_off_q, lfd_off_d;
    logic lfd_on_q, lfd_on_d;
    logic pause_action_q, pause_action_d;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= PH_IDLE;
            mode_q         <= MODE_ENABLE;
            win_q          <= '0;
            count_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            phase_start_q  <= 1'b0;
            lfd_off_q      <= 1'b0;
            lfd_on_q       <= 1'b0;
            pause_action_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            win_q          <= win_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            phase_start_q  <= phase_start_d;
            lfd_off_q      <= lfd_off_d;
            lfd_on_q       <= lfd_on_d;
            pause_action_q <= pause_action_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        win_d   = win_q;
        count_d = count_q;
        err_d   = 1'b0;
        unique case (state_q)
            PH_IDLE: begin
                if (bus.start) begin
                    if (mode_e'(bus.mode) == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = PH_SEND;
                        mode_d  = mode_e'(bus.mode);
                        count_d = windows_for(mode_e'(bus.mode));
                        win_d   = '0;
                    end
                end
            end
            PH_SEND:     if (timer_tc) state_d = PH_INCREASE;
            PH_INCREASE: if (timer_tc) state_d = PH_PAUSE;
            PH_PAUSE:    if (timer_tc) state_d = PH_LISTEN;
            PH_LISTEN: begin
                if (timer_tc) begin
                    if (win_q == count_q - 1'b1) begin
                        state_d = PH_DONE;
                    end else begin
                        state_d = PH_SEND;
                        win_d   = win_q + 1'b1;
                    end
                end
            end
            PH_DONE: state_d = PH_IDLE;
            default: state_d = PH_IDLE;
        endcase
        // Abort overrides any phase progress; start is only looked at in IDLE.
        if (state_q != PH_IDLE && bus.abort) begin
            state_d = PH_IDLE;
        end
        if (state_d == PH_IDLE) begin
            win_d = '0;
        end

        timer_load = (state_d != state_q) &&
                     (state_d inside {PH_SEND, PH_INCREASE, PH_PAUSE, PH_LISTEN});
        case (state_d)
            PH_SEND:     timer_val = CNT_W'(C_SEND - 1);
            PH_INCREASE: timer_val = CNT_W'(C_INCREASE - 1);
            PH_PAUSE:    timer_val = CNT_W'(C_PAUSE - 1);
            PH_LISTEN:   timer_val = CNT_W'(C_LISTEN - 1);
            default:     timer_val = '0;
        endcase
    end

    always_comb begin
        busy_d         = (state_d != PH_IDLE);
        done_d         = (state_d == PH_DONE);
        phase_start_d  = (state_d != state_q) && (state_d != PH_IDLE);
        lfd_off_d      = (state_d == PH_SEND) && (mode_d == MODE_CALIBRATE);
        lfd_on_d       = (state_d == PH_DONE) && (mode_d == MODE_CALIBRATE);
        pause_action_d = (state_d == PH_PAUSE) && (state_q != PH_PAUSE) &&
                         (mode_d == MODE_CALIBRATE);
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.phase        = state_q;
    assign bus.window_idx   = win_q;
    assign bus.phase_start  = phase_start_q;
    assign bus.lfd_off      = lfd_off_q;
    assign bus.lfd_on       = lfd_on_q;
    assign bus.pause_action = pause_action_q;
endmodule

// File: tb/tb_window_sequencer.sv
// Randomized bench for window_sequencer at 1 MHz timing, checked against a
// run-offset reference model (500-cycle windows: 30/350/5/115).
module tb_window_sequencer;
    localparam int WIN_W  = 8;
    localparam int WIN_LEN = 500;

    logic clk = 1'b0;
    logic rst;

    window_sequencer_if #(.WIN_W(WIN_W)) bus ();

    window_sequencer #(
        .CLK_FREQ_MHZ   (1),
        .SEND_US        (30),
        .INCREASE_US    (350),
        .PAUSE_US       (5),
        .LISTEN_US      (115),
        .CNT_W          (16),
        .WIN_W          (WIN_W),
        .ENABLE_WINDOWS (3),
        .CALIB_WINDOWS  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a run is described only by its offset from the first SEND cycle.
    bit m_run = 0;
    bit m_err = 0;
    int m_t   = 0;
    int m_mode = 0;
    int m_n   = 0;

    int a_busy, a_done, a_ps, a_lfdoff, a_lfdon, a_pa, a_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 0;
            m_err = 0;
        end else if (m_run) begin
            m_err = 0;
            if (bus.abort || m_t == m_n * WIN_LEN) m_run = 0;
            else m_t++;
        end else begin
            m_err = bus.start && (bus.mode == 2'b11);
            if (bus.start && bus.mode != 2'b11) begin
                m_run  = 1;
                m_t    = 0;
                m_mode = int'(bus.mode);
                m_n    = (m_mode == 0) ? 3 : (m_mode == 1) ? 20 : 1;
            end
        end
    endtask

    // {busy, done, err, phase[2:0], phase_start, lfd_off, lfd_on, pause_action}
    function automatic logic [9:0] exp_outs();
        int r, ph;
        bit cal;
        if (!m_run) return {2'b00, m_err, 7'd0};
        cal = (m_mode == 1);
        if (m_t == m_n * WIN_LEN) return {3'b110, 3'd5, 1'b1, 1'b0, cal, 1'b0};
        r = m_t % WIN_LEN;
        ph = (r < 30) ? 1 : (r < 380) ? 2 : (r < 385) ? 3 : 4;
        return {3'b100, 3'(ph), (r == 0 || r == 30 || r == 380 || r == 385),
                cal && (ph == 1), 1'b0, cal && (r == 380)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("outs", {22'd0, bus.busy, bus.done, bus.err, bus.phase, bus.phase_start,
                       bus.lfd_off, bus.lfd_on, bus.pause_action}, {22'd0, exp_outs()});
        if (m_run && m_t < m_n * WIN_LEN)
            check("window_idx", 32'(bus.window_idx), 32'(m_t / WIN_LEN));
        a_busy   += int'(bus.busy);
        a_done   += int'(bus.done);
        a_ps     += int'(bus.phase_start);
        a_lfdoff += int'(bus.lfd_off);
        a_lfdon  += int'(bus.lfd_on);
        a_pa     += int'(bus.pause_action);
        a_err    += int'(bus.err);
    endtask

    task automatic clear_agg();
        a_busy = 0; a_done = 0; a_ps = 0; a_lfdoff = 0; a_lfdon = 0; a_pa = 0; a_err = 0;
    endtask

    // Inputs change only after the check, i.e. 1 time unit past the active edge.
    task automatic run_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (noise && m_run) begin
                bus.start = (m_t == m_n * WIN_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.mode  = 2'($urandom_range(0, 3));
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic launch(input logic [1:0] md);
        bus.start = 1'b1;
        bus.mode  = md;
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.abort = 1'b0;
        clear_agg();
        run_cycles(3, 1'b0);
        check("reset_window_idx", 32'(bus.window_idx), 32'd0);
        rst = 1'b0;
        run_cycles(2, 1'b0);

        // ENABLE run, abort held high while idle must not matter
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        clear_agg();
        launch(2'b00);
        run_cycles(1505, 1'b0);
        check("enable_busy_cycles", a_busy, 1501);
        check("enable_phase_starts", a_ps, 13);
        check("enable_done", a_done, 1);
        check("enable_lfd", a_lfdoff + a_lfdon + a_pa, 0);

        // CALIBRATE run with start/mode noise throughout
        clear_agg();
        launch(2'b01);
        run_cycles(10005, 1'b1);
        check("calib_lfd_off_cycles", a_lfdoff, 600);
        check("calib_pause_actions", a_pa, 20);
        check("calib_lfd_on", a_lfdon, 1);
        check("calib_done", a_done, 1);
        check("calib_busy_cycles", a_busy, 10001);

        // Reserved mode, then TEST
        clear_agg();
        launch(2'b11);
        run_cycles(3, 1'b0);
        check("rsvd_err", a_err, 1);
        check("rsvd_busy", a_busy, 0);
        clear_agg();
        launch(2'b10);
        run_cycles(505, 1'b0);
        check("test_busy_cycles", a_busy, 501);
        check("test_done", a_done, 1);

        // Abort at cycle 200, then a clean restart
        clear_agg();
        launch(2'b00);
        for (int i = 0; i < 400 && m_t < 200; i++) run_cycles(1, 1'b0);
        check("abort_reach_200", m_t, 200);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("abort_phase", 32'(bus.phase), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        run_cycles(3, 1'b0);
        check("abort_no_done", a_done, 0);
        clear_agg();
        launch(2'b00);
        run_cycles(1505, 1'b0);
        check("restart_done", a_done, 1);

        // Reset during window 7 PAUSE of a CALIBRATE run
        launch(2'b01);
        for (int i = 0; i < 4000 && m_t < 3882; i++) run_cycles(1, 1'b1);
        check("rst_reach_pause", m_t, 3882);
        rst = 1'b1;
        bus.start = 1'b0;
        cyc();
        check("rst_midrun_window_idx", 32'(bus.window_idx), 32'd0);
        rst = 1'b0;
        run_cycles(3, 1'b0);

        // Random runs with random abort points
        for (int k = 0; k < 8; k++) begin
            int abort_at;
            int pick;
            bus.abort = 1'($urandom_range(0, 1));
            run_cycles($urandom_range(1, 4), 1'b0);
            bus.abort = 1'b0;
            pick = $urandom_range(0, 2);
            launch((pick == 0) ? 2'b00 : (pick == 1) ? 2'b10 : 2'b11);
            abort_at = $urandom_range(0, 3000);
            for (int i = 0; i < 1600 && m_run; i++) begin
                bus.abort = (m_t == abort_at);
                run_cycles(1, 1'b1);
            end
            bus.abort = 1'b0;
            check("random_run_ended", 32'(m_run), 32'd0);
            run_cycles(2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
